// File: rtl/sg13g2_pad_ctrl.sv
// sg13g2 pad-ring controller: per-pad mode/pull config, combinational output
// drive, and a synchronised, glitch-filtered input path with edge pulses.

// One pad: output-mode decode, pull decode, 2-flop sync and stability filter.
module sg13g2_pad_lane #(
  parameter int FiltLen = 4,
  parameter int CntW    = $clog2(FiltLen + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] cfg,
  input  logic       core_d,
  input  logic       pad_in,
  output logic       core_q,
  output logic       rise,
  output logic       fall,
  output logic       pad_d,
  output logic       pad_oe,
  output logic       pad_pu,
  output logic       pad_pd
);
  typedef enum logic [1:0] {MODE_IN, MODE_OUT, MODE_OD, MODE_OFF} mode_e;

  mode_e           mode;
  logic            s1, s2, st;
  logic [CntW-1:0] cnt;

  assign mode   = mode_e'(cfg[1:0]);
  assign pad_pu = cfg[2];
  assign pad_pd = cfg[3] & ~cfg[2];
  assign core_q = st;

  // Output drive: open-drain only ever drives low, so d stays 0 and oe carries the data.
  always_comb begin
    pad_d  = 1'b0;
    pad_oe = 1'b0;
    case (mode)
      MODE_OUT: begin
        pad_oe = 1'b1;
        pad_d  = core_d;
      end
      MODE_OD: pad_oe = ~core_d;
      default: ;
    endcase
  end

  // Sync + filter: a new level is accepted after FiltLen consecutive differing samples.
  // OFF holds the whole path cleared so leaving OFF restarts from a known 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || mode == MODE_OFF) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      st   <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= pad_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == CntW'(FiltLen - 1)) begin
        st   <= s2;
        cnt  <= '0;
        rise <= s2;
        fall <= ~s2;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end
endmodule

module sg13g2_pad_ctrl #(
  parameter int NumPads = 8,
  parameter int FiltLen = 4,
  parameter int IdxW    = (NumPads > 1) ? $clog2(NumPads) : 1,
  parameter int CntW    = $clog2(FiltLen + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_we_i,
  input  logic [IdxW-1:0]    cfg_idx_i,
  input  logic [3:0]         cfg_wdata_i,
  output logic [3:0]         cfg_rdata_o,
  input  logic [NumPads-1:0] core_d_i,
  output logic [NumPads-1:0] core_d_o,
  output logic [NumPads-1:0] core_rise_o,
  output logic [NumPads-1:0] core_fall_o,
  output logic [NumPads-1:0] pad_d_o,
  output logic [NumPads-1:0] pad_oe_o,
  output logic [NumPads-1:0] pad_pu_o,
  output logic [NumPads-1:0] pad_pd_o,
  input  logic [NumPads-1:0] pad_d_i
);
  logic [NumPads-1:0][3:0] cfg_q;

  // Config write; indices with no matching pad simply match nothing and are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= '0;
    end else if (cfg_we_i) begin
      for (int p = 0; p < NumPads; p++)
        if (cfg_idx_i == IdxW'(p)) cfg_q[p] <= cfg_wdata_i;
    end
  end

  // Readback mux; out-of-range indices fall through to 0.
  always_comb begin
    cfg_rdata_o = 4'b0000;
    for (int p = 0; p < NumPads; p++)
      if (cfg_idx_i == IdxW'(p)) cfg_rdata_o = cfg_q[p];
  end

  for (genvar p = 0; p < NumPads; p++) begin : g_pad
    sg13g2_pad_lane #(.FiltLen(FiltLen), .CntW(CntW)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cfg    (cfg_q[p]),
      .core_d (core_d_i[p]),
      .pad_in (pad_d_i[p]),
      .core_q (core_d_o[p]),
      .rise   (core_rise_o[p]),
      .fall   (core_fall_o[p]),
      .pad_d  (pad_d_o[p]),
      .pad_oe (pad_oe_o[p]),
      .pad_pu (pad_pu_o[p]),
      .pad_pd (pad_pd_o[p])
    );
  end
endmodule
